// File: rtl/weight_optimization_pkg.sv
// Shared Q2.8 fixed-point definitions for the backprop delta datapath.
// Holds the data format parameters, the signed data typedef and the saturation helper.
package weight_optimization_pkg;

    localparam int DATA_W  = 10;
    localparam int FRAC_W  = 8;
    localparam int N_OUT   = 3;
    localparam int N_HID   = 5;
    localparam int WIDE_W  = 12;
    localparam int CHAIN_W = DATA_W * N_OUT * N_HID;

    localparam logic signed [31:0] Q_MAX = 32'sd511;
    localparam logic signed [31:0] Q_MIN = -32'sd512;

    typedef logic signed [DATA_W-1:0] q28_t;
    typedef logic signed [WIDE_W-1:0] q28_wide_t;

    // Clamp any sign-extended intermediate into the Q2.8 range.
    function automatic q28_t sat_q28(input logic signed [31:0] x);
        q28_t r;
        if (x > Q_MAX) begin
            r = 10'sd511;
        end else if (x < Q_MIN) begin
            r = -10'sd512;
        end else begin
            r = x[DATA_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/weight_optimization_fx_mul_sat.sv
// Q2.8 multiply: full-width signed product, floor shift by FRAC_W, saturate to Q2.8.
// Operand widths are parameters so the 12-bit (1 - x) terms need no pre-saturation.
module fx_mul_sat
    import weight_optimization_pkg::*;
#(
    parameter int A_W = 10,
    parameter int B_W = 10
) (
    input  logic signed [A_W-1:0] a,
    input  logic signed [B_W-1:0] b,
    output q28_t                  p
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0] prod;
    logic signed [P_W-1:0] prod_shr;

    always_comb begin
        prod     = P_W'(a) * P_W'(b);
        // Arithmetic shift gives floor rounding for negative products.
        prod_shr = prod >>> FRAC_W;
        p        = sat_q28(32'(prod_shr));
    end

endmodule

// File: rtl/weight_optimization.sv
// Output- and hidden-layer delta computation with a serially loaded 15-entry weight store.
// WE=1 shifts weights in and freezes the pipeline; WE=0 computes delta1 then delta0.
module weight_optimization
    import weight_optimization_pkg::*;
(
    input  logic Clock,
    input  logic Rst,
    input  logic WE,
    input  logic In,
    input  q28_t out1_actual [0:N_OUT-1],
    input  q28_t out1_cal    [0:N_OUT-1],
    input  q28_t out0_cal    [0:N_HID-1],
    output q28_t delta1      [0:N_OUT-1],
    output q28_t delta0      [0:N_HID-1]
);

    logic [CHAIN_W-1:0] chain_q, chain_d;
    q28_t delta1_q [0:N_OUT-1];
    q28_t delta1_d [0:N_OUT-1];
    q28_t delta0_q [0:N_HID-1];
    q28_t delta0_d [0:N_HID-1];
    q28_t out0_q   [0:N_HID-1];
    q28_t out0_d   [0:N_HID-1];

    q28_t      w        [0:N_OUT-1][0:N_HID-1];
    q28_wide_t e_wide   [0:N_OUT-1];
    q28_t      e        [0:N_OUT-1];
    q28_wide_t dsub     [0:N_OUT-1];
    q28_t      d        [0:N_OUT-1];
    q28_t      d1_nxt   [0:N_OUT-1];
    q28_wide_t hsub     [0:N_HID-1];
    q28_t      h        [0:N_HID-1];
    logic signed [21:0] acc [0:N_HID-1];
    q28_t      s        [0:N_HID-1];
    q28_t      d0_nxt   [0:N_HID-1];

    // Weight W[k][j] sits at entry 5k+j, with entry 0 at the top of the chain.
    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            for (int j = 0; j < N_HID; j++) begin
                w[k][j] = chain_q[CHAIN_W-1-DATA_W*(N_HID*k+j) -: DATA_W];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            e_wide[k] = WIDE_W'(out1_actual[k]) - WIDE_W'(out1_cal[k]);
            e[k]      = sat_q28(32'(e_wide[k]));
            dsub[k]   = 12'sd256 - WIDE_W'(out1_cal[k]);
        end
    end

    always_comb begin
        for (int j = 0; j < N_HID; j++) begin
            hsub[j] = 12'sd256 - WIDE_W'(out0_q[j]);
            acc[j]  = '0;
            for (int k = 0; k < N_OUT; k++) begin
                acc[j] = acc[j] + 22'(w[k][j]) * 22'(delta1_q[k]);
            end
            s[j] = sat_q28(32'(acc[j] >>> FRAC_W));
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        fx_mul_sat #(.A_W(DATA_W), .B_W(WIDE_W)) u_mul_d (
            .a (out1_cal[k]),
            .b (dsub[k]),
            .p (d[k])
        );
        fx_mul_sat #(.A_W(DATA_W), .B_W(DATA_W)) u_mul_delta1 (
            .a (e[k]),
            .b (d[k]),
            .p (d1_nxt[k])
        );
    end

    for (genvar j = 0; j < N_HID; j++) begin : g_hid
        fx_mul_sat #(.A_W(DATA_W), .B_W(WIDE_W)) u_mul_h (
            .a (out0_q[j]),
            .b (hsub[j]),
            .p (h[j])
        );
        fx_mul_sat #(.A_W(DATA_W), .B_W(DATA_W)) u_mul_delta0 (
            .a (s[j]),
            .b (h[j]),
            .p (d0_nxt[j])
        );
    end

    // Loading and computing are mutually exclusive: each holds the other's state.
    always_comb begin
        chain_d  = chain_q;
        delta1_d = delta1_q;
        delta0_d = delta0_q;
        out0_d   = out0_q;
        if (WE) begin
            chain_d = {chain_q[CHAIN_W-2:0], In};
        end else begin
            delta1_d = d1_nxt;
            delta0_d = d0_nxt;
            out0_d   = out0_cal;
        end
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            chain_q <= '0;
            for (int k = 0; k < N_OUT; k++) begin
                delta1_q[k] <= '0;
            end
            for (int j = 0; j < N_HID; j++) begin
                delta0_q[j] <= '0;
                out0_q[j]   <= '0;
            end
        end else begin
            chain_q  <= chain_d;
            delta1_q <= delta1_d;
            delta0_q <= delta0_d;
            out0_q   <= out0_d;
        end
    end

    assign delta1 = delta1_q;
    assign delta0 = delta0_q;

endmodule

// File: tb/tb_weight_optimization.sv
// Directed self-checking bench for weight_optimization with hand-computed Q2.8 expectations.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_weight_optimization;

    logic              Clock;
    logic              Rst;
    logic              WE;
    logic              In;
    logic signed [9:0] out1_actual [0:2];
    logic signed [9:0] out1_cal    [0:2];
    logic signed [9:0] out0_cal    [0:4];
    logic signed [9:0] delta1      [0:2];
    logic signed [9:0] delta0      [0:4];

    int n_vec;
    int n_err;

    weight_optimization dut (
        .Clock       (Clock),
        .Rst         (Rst),
        .WE          (WE),
        .In          (In),
        .out1_actual (out1_actual),
        .out1_cal    (out1_cal),
        .out0_cal    (out0_cal),
        .delta1      (delta1),
        .delta0      (delta0)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_inputs(input logic signed [9:0] act, input logic signed [9:0] cal,
                              input logic signed [9:0] o0);
        for (int k = 0; k < 3; k++) begin
            out1_actual[k] = act;
            out1_cal[k]    = cal;
        end
        for (int j = 0; j < 5; j++) begin
            out0_cal[j] = o0;
        end
    endtask

    task automatic shift_word(input logic [9:0] wv);
        WE = 1'b1;
        for (int i = 9; i >= 0; i--) begin
            In = wv[i];
            tick();
        end
    endtask

    task automatic load_all(input logic [9:0] wv);
        for (int n = 0; n < 15; n++) begin
            shift_word(wv);
        end
        WE = 1'b0;
        In = 1'b0;
    endtask

    task automatic check_d1(input string name, input logic signed [9:0] exp_v);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (delta1[k] !== exp_v) begin
                n_err++;
                $display("FAIL %s delta1[%0d] got %0d expected %0d", name, k, delta1[k], exp_v);
            end
        end
    endtask

    task automatic check_d0(input string name, input logic signed [9:0] exp_v);
        for (int j = 0; j < 5; j++) begin
            n_vec++;
            if (delta0[j] !== exp_v) begin
                n_err++;
                $display("FAIL %s delta0[%0d] got %0d expected %0d", name, j, delta0[j], exp_v);
            end
        end
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        WE  = 1'b0;
        In  = 1'b0;
        set_inputs(10'sd256, 10'sd128, 10'sd128);
        #2;
        check_d1("reset_init", 10'sd0);
        check_d0("reset_init", 10'sd0);
        // Edges while reset is low must not move the outputs.
        tick();
        tick();
        check_d1("reset_held", 10'sd0);
        check_d0("reset_held", 10'sd0);
        @(negedge Clock);
        Rst = 1'b1;
        #4;
    endtask

    task automatic test_basic_delta1();
        // e=128, d=128*128>>8=64, delta1=128*64>>8=32; all weights zero so delta0=0.
        set_inputs(10'sd256, 10'sd128, 10'sd128);
        WE = 1'b0;
        tick();
        check_d1("basic_delta1", 10'sd32);
        tick();
        check_d0("zero_weights", 10'sd0);
    endtask

    task automatic test_hidden_delta();
        // W=256: s=3*256*32>>8=96, h=128*128>>8=64, delta0=96*64>>8=24.
        load_all(10'sd256);
        set_inputs(10'sd256, 10'sd128, 10'sd128);
        tick();
        check_d1("hidden_d1", 10'sd32);
        tick();
        check_d0("hidden_delta0", 10'sd24);
    endtask

    task automatic test_saturation();
        logic signed [9:0] exp_v;
        set_inputs(10'sd256, 10'sd128, 10'sd128);
        out1_actual[0] = 10'b0111010010;
        out1_cal[0]    = 10'b1111001101;
        tick();
        exp_v = 10'b1110000100;
        n_vec++;
        if (delta1[0] !== exp_v) begin
            n_err++;
            $display("FAIL sat_floor delta1[0] got %0d expected %0d", delta1[0], exp_v);
        end
        for (int k = 1; k < 3; k++) begin
            n_vec++;
            if (delta1[k] !== 10'sd32) begin
                n_err++;
                $display("FAIL sat_others delta1[%0d] got %0d expected 32", k, delta1[k]);
            end
        end
        // s=(256*(-124+32+32))>>8=-60, delta0=-60*64>>8=-15.
        tick();
        check_d0("sat_delta0", -10'sd15);
    endtask

    task automatic test_back_to_back();
        // cal=256 gives d=256*0=0 -> delta1=0.
        set_inputs(10'sd256, 10'sd256, 10'sd128);
        tick();
        check_d1("b2b_zero", 10'sd0);
        // e=-128, d=64 -> -8192>>8=-32.
        set_inputs(10'sd0, 10'sd128, 10'sd128);
        tick();
        check_d1("b2b_neg", -10'sd32);
        // delta0 from the previous delta1=0.
        check_d0("b2b_d0_lag", 10'sd0);
        tick();
        // s=3*256*(-32)>>8=-96, delta0=-96*64>>8=-24.
        check_d0("b2b_d0_neg", -10'sd24);
    endtask

    task automatic test_load_freeze();
        logic [9:0] w00;
        set_inputs(10'sd256, 10'sd128, 10'sd128);
        tick();
        tick();
        check_d0("freeze_pre", 10'sd24);
        // Inputs that would give delta1=0 if the pipeline were not frozen.
        set_inputs(10'sd256, 10'sd256, 10'sd0);
        w00 = 10'sd128;
        WE  = 1'b1;
        for (int i = 9; i >= 0; i--) begin
            In = w00[i];
            tick();
            n_vec++;
            if (delta1[0] !== 10'sd32 || delta0[0] !== 10'sd24) begin
                n_err++;
                $display("FAIL freeze_hold bit %0d got d1=%0d d0=%0d expected 32/24", i, delta1[0], delta0[0]);
            end
        end
        for (int n = 0; n < 14; n++) begin
            shift_word(10'd0);
        end
        WE = 1'b0;
        In = 1'b0;
        set_inputs(10'sd256, 10'sd128, 10'sd128);
        tick();
        tick();
        check_d1("freeze_resume_d1", 10'sd32);
        // Only W[0][0]=128: s0=128*32>>8=16, delta0[0]=16*64>>8=4.
        n_vec++;
        if (delta0[0] !== 10'sd4) begin
            n_err++;
            $display("FAIL freeze_w00 delta0[0] got %0d expected 4", delta0[0]);
        end
        for (int j = 1; j < 5; j++) begin
            n_vec++;
            if (delta0[j] !== 10'sd0) begin
                n_err++;
                $display("FAIL freeze_wzero delta0[%0d] got %0d expected 0", j, delta0[j]);
            end
        end
    endtask

    task automatic test_reset_midcycle();
        @(posedge Clock);
        #3;
        Rst = 1'b0;
        #1;
        check_d1("midreset", 10'sd0);
        check_d0("midreset", 10'sd0);
        @(negedge Clock);
        Rst = 1'b1;
        #4;
        // Weights were cleared, so delta0 stays zero for nonzero delta1.
        set_inputs(10'sd256, 10'sd128, 10'sd128);
        tick();
        check_d1("post_reset_d1", 10'sd32);
        tick();
        check_d0("post_reset_w0", 10'sd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic_delta1();
        test_hidden_delta();
        test_saturation();
        test_back_to_back();
        test_load_freeze();
        test_reset_midcycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/weight_optimization.md
WEIGHT_OPTIMIZATION -- requirements
Module: weight_optimization

Interface
REQ-001 SHALL have port: Clock  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: Rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: WE  input  1  weight-load enable; 1 = shift in weights, 0 = compute.
REQ-004 SHALL have port: In  input  1  serial weight data bit, sampled when WE=1.
REQ-005 SHALL have port: out1_actual[0:2]  input  3x10  target output-layer values.
REQ-006 SHALL have port: out1_cal[0:2]  input  3x10  computed output-layer activations.
REQ-007 SHALL have port: out0_cal[0:4]  input  5x10  computed hidden-layer activations.
REQ-008 SHALL have port: delta1[0:2]  output  3x10  registered output-layer deltas.
REQ-009 SHALL have port: delta0[0:4]  output  5x10  registered hidden-layer deltas.

Function
REQ-010 All data SHALL be signed two's-complement Q2.8 (10 bits; 1.0 = 256; range -512..511).
REQ-011 Every multiply SHALL form the full 20-bit product, arithmetic-shift right 8 (floor), then saturate to -512..511.
REQ-012 Every add/subtract SHALL be computed 12 bits wide, then saturated to -512..511.
REQ-013 Internal weight store SHALL be W[k][j], k=0..2 (output), j=0..4 (hidden): 15x10 bits, a 150-bit shift chain.
REQ-014 When WE=1, each edge SHALL do chain <= {chain[148:0], In}; W[k][j] = chain[149-10*(5k+j) -: 10], so serial order is W[0][0] MSB first through W[2][4] LSB last (150 cycles).
REQ-015 When WE=1, delta1 and delta0 SHALL hold their values.
REQ-016 When WE=0, each edge: e_k = sat(out1_actual[k]-out1_cal[k]); d_k = mul(out1_cal[k], sat12(256-out1_cal[k]) unsaturated before multiply); delta1[k] <= mul(e_k, d_k).
REQ-017 When WE=0, each edge SHALL also register out0_cal into out0_q.
REQ-018 When WE=0, each edge: s_j = sat((sum over k of W[k][j]*delta1[k], full 22-bit precision) >>> 8); delta0[j] <= mul(s_j, mul(out0_q[j], 256-out0_q[j])), using the currently registered delta1.
REQ-019 Latency: delta1 valid 1 edge after inputs applied; delta0 valid 2 edges after, inputs held constant and WE=0.
REQ-020 A WE 0->1 transition mid-computation SHALL freeze the pipeline; results resume, with the new weights, once WE returns to 0.

Reset
REQ-021 Rst=0 SHALL immediately clear delta1, delta0, out0_q and all 150 weight bits to zero, independent of Clock.
REQ-022 Deassertion SHALL take effect at the next rising Clock edge; no output changes while Rst=0.

Structure
REQ-023 A shared package SHALL hold DATA_W=10, FRAC_W=8, N_OUT=3, N_HID=5, the Q2.8 signed typedef and a saturate function.
REQ-024 A single sub-module fx_mul_sat (Q2.8 multiply, floor shift, saturate) SHALL be instantiated for every product except the W*delta1 accumulation.

Verification
REQ-025 Reset: assert Rst=0 mid-cycle -> delta1, delta0 all 0 immediately; weights read back 0 (delta0 stays 0 for any delta1).
REQ-026 Basic delta1: WE=0, out1_actual=256, out1_cal=128 (all k) -> after 1 edge delta1[k]=32.
REQ-027 Hidden delta: load all W=256 via 150 serial bits, then out1_actual=256, out1_cal=128, out0_cal=128 -> after 2 edges delta0[j]=24; with all W=0, delta0[j]=0.
REQ-028 Saturation and rounding: out1_actual[0]=10'b0111010010 (466), out1_cal[0]=10'b1111001101 (-51) -> e saturates to 511, d=-62, delta1[0]=-124 (10'b1110000100).
REQ-029 Load freeze: toggle WE=1 for 10 cycles mid-computation -> delta1/delta0 unchanged during load; W[0][0] equals the 10 shifted bits after exactly 150 total shifts.
